// File: rtl/p1v_pin_bank.sv
// Pad-side I/O bank for the p1v core: registered pad outputs, synchronised and
// optionally glitch-filtered inputs with edge flags, external reset conditioner, LED drive.
module p1v_pin_bank #(
    parameter int PINS           = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int FILT_LEN       = 16,
    parameter int RST_HOLD       = 1024,
    parameter int LEDS           = 8,
    parameter int LED_ACTIVE_LOW = 1
) (
    input  logic            clock_160,
    input  logic            inp_resn,
    input  logic [PINS-1:0] pad_in,
    output logic [PINS-1:0] pad_out,
    output logic [PINS-1:0] pad_oe,
    input  logic [PINS-1:0] pin_out,
    input  logic [PINS-1:0] pin_dir,
    input  logic [PINS-1:0] filt_en,
    output logic [PINS-1:0] pin_in,
    output logic [PINS-1:0] pin_rise,
    output logic [PINS-1:0] pin_fall,
    input  logic            ext_resn,
    output logic            core_resn,
    input  logic [LEDS-1:0] cogled,
    output logic [LEDS-1:0] led
);

    localparam int   CW      = $clog2(FILT_LEN);
    localparam int   HW      = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic LED_POL = (LED_ACTIVE_LOW != 0);

    typedef enum logic {HOLD, RUN} rst_state_t;

    logic [PINS-1:0] sync_p [SYNC_STAGES];
    logic [PINS-1:0] s_p1;
    logic [CW-1:0]   cnt_q  [PINS];
    logic [1:0]      rsync_q;
    logic            r_p1;
    rst_state_t      state_q, state_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;

    // Output stage: pads follow the core one edge later
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            pad_out <= '0;
            pad_oe  <= '0;
        end else begin
            pad_out <= pin_out;
            pad_oe  <= pin_dir;
        end
    end

    // Input synchroniser: pads are read regardless of direction
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_p[k] <= '0;
        end else begin
            sync_p[0] <= pad_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_p[k] <= sync_p[k-1];
        end
    end

    assign s_p1 = sync_p[SYNC_STAGES-1];

    // Filter stage: any cycle where s agrees with pin_in discards a partial count
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            for (int i = 0; i < PINS; i++) cnt_q[i] <= '0;
            pin_in   <= '0;
            pin_rise <= '0;
            pin_fall <= '0;
        end else begin
            for (int i = 0; i < PINS; i++) begin
                pin_rise[i] <= 1'b0;
                pin_fall[i] <= 1'b0;
                if (s_p1[i] == pin_in[i]) begin
                    cnt_q[i] <= '0;
                end else if (!filt_en[i] || cnt_q[i] == CW'(FILT_LEN - 1)) begin
                    pin_in[i]   <= s_p1[i];
                    pin_rise[i] <= s_p1[i];
                    pin_fall[i] <= ~s_p1[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Reset conditioner: synchronise, then require RST_HOLD clean cycles
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            rsync_q <= '0;
            state_q <= HOLD;
            hcnt_q  <= '0;
        end else begin
            rsync_q <= {rsync_q[0], ext_resn};
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign r_p1 = rsync_q[1];

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        case (state_q)
            HOLD: begin
                if (!r_p1) begin
                    hcnt_d = '0;
                end else if (hcnt_q == HW'(RST_HOLD - 1)) begin
                    state_d = RUN;
                    hcnt_d  = '0;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            RUN: begin
                if (!r_p1) begin
                    state_d = HOLD;
                    hcnt_d  = '0;
                end
            end
            default: begin
                state_d = HOLD;
                hcnt_d  = '0;
            end
        endcase
    end

    assign core_resn = (state_q == RUN);

    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) led <= {LEDS{LED_POL}};
        else           led <= cogled ^ {LEDS{LED_POL}};
    end

endmodule
